// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction cache: fetch-address view, frame layout and FSM states.
package cpu_types_pkg;

  localparam int unsigned SETS  = 16;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned TAG_W = 26;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [1:0]       bytoff;
  } icachef_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    word_t            data;
  } icache_block_t;

  typedef enum logic {IDLE, FETCH} icache_state_t;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped frame store: async read, one sync write port, single-cycle invalidate-all.
module icache_array
  import cpu_types_pkg::*;
(
  input  logic               CLK,
  input  logic               nRST,
  input  logic [IDX_W-1:0]   idx,
  output icache_block_t      rblock,
  input  logic               we,
  input  logic [IDX_W-1:0]   widx,
  input  icache_block_t      wblock,
  input  logic               flush_all
);

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags  [SETS];
  word_t            words [SETS];

  // A fill landing on the flush edge overrides the clear for its own frame.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= '0;
    end else begin
      if (flush_all) valid <= '0;
      if (we)        valid[widx] <= wblock.valid;
    end
  end

  always_ff @(posedge CLK) begin
    if (we) begin
      tags[widx]  <= wblock.tag;
      words[widx] <= wblock.data;
    end
  end

  always_comb begin
    rblock       = '0;
    rblock.valid = valid[idx];
    rblock.tag   = tags[idx];
    rblock.data  = words[idx];
  end

endmodule

// File: rtl/icache_ctrl.sv
// Instruction-cache controller: zero-latency hit compare, miss latch, refill FSM, miss counter.
module icache_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic             ihit,
  output logic [31:0]      imemload,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             iwait,
  input  logic [31:0]      iload,
  input  logic             flush,
  output logic [CNT_W-1:0] miss_count
);

  icache_state_t    state;
  logic [TAG_W-1:0] miss_tag;
  logic [IDX_W-1:0] miss_idx;
  icachef_t         addr_f;
  icache_block_t    rblock;
  icache_block_t    wblock;
  logic             raw_hit;
  logic             fill_we;
  logic             unused_bytoff;

  assign addr_f        = icachef_t'(imemaddr);
  assign unused_bytoff = ^addr_f.bytoff;

  icache_array u_array (
    .CLK       (CLK),
    .nRST      (nRST),
    .idx       (addr_f.idx),
    .rblock    (rblock),
    .we        (fill_we),
    .widx      (miss_idx),
    .wblock    (wblock),
    .flush_all (flush)
  );

  assign raw_hit = imemREN && rblock.valid && (rblock.tag == addr_f.tag);
  assign fill_we = (state == FETCH) && !iwait;

  always_comb begin
    wblock       = '0;
    wblock.valid = 1'b1;
    wblock.tag   = miss_tag;
    wblock.data  = iload;
  end

  // Outputs decode directly from state; only the FSM, latch and counter are registered.
  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    if (state == FETCH) begin
      iREN  = 1'b1;
      iaddr = {miss_tag, miss_idx, 2'b00};
    end else if (raw_hit && !flush) begin
      ihit     = 1'b1;
      imemload = rblock.data;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      miss_tag   <= '0;
      miss_idx   <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (imemREN && !raw_hit) begin
            miss_tag <= addr_f.tag;
            miss_idx <= addr_f.idx;
            if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (!iwait) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl; a second instance with a 2-bit counter checks saturation.
module tb_icache_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        flush;
  logic [15:0] miss_count;

  logic        ihit_s;
  logic [31:0] imemload_s;
  logic        iREN_s;
  logic [31:0] iaddr_s;
  logic [1:0]  mc_sat;

  int pass  = 0;
  int total = 0;

  always #5 CLK = ~CLK;

  icache_ctrl #(.CNT_W(16)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .flush      (flush),
    .miss_count (miss_count)
  );

  icache_ctrl #(.CNT_W(2)) dut_sat (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit_s),
    .imemload   (imemload_s),
    .iREN       (iREN_s),
    .iaddr      (iaddr_s),
    .iwait      (iwait),
    .iload      (iload),
    .flush      (flush),
    .miss_count (mc_sat)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    imemREN  = 1'b0;
    imemaddr = '0;
    iwait    = 1'b1;
    iload    = '0;
    flush    = 1'b0;
    nRST     = 1'b1;
    #1 nRST  = 1'b0;
    #2 nRST  = 1'b1;
    step();
  endtask

  // Caller has already presented a missing address in IDLE.
  task automatic do_miss(input logic [31:0] data, input int waits);
    iwait = 1'b1;
    step();
    repeat (waits) step();
    iwait = 1'b0;
    iload = data;
    step();
    iwait = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    nRST = 1'b0;
    #1;
    total++; if (ihit !== 1'b0) $display("FAIL reset_ihit got=%0b exp=0", ihit); else pass++;
    total++; if (iREN !== 1'b0) $display("FAIL reset_iREN got=%0b exp=0", iREN); else pass++;
    total++; if (iaddr !== 32'h0) $display("FAIL reset_iaddr got=%h exp=0", iaddr); else pass++;
    total++; if (imemload !== 32'h0) $display("FAIL reset_imemload got=%h exp=0", imemload);
             else pass++;
    total++; if (miss_count !== 16'd0) $display("FAIL reset_count got=%0d exp=0", miss_count);
             else pass++;
    nRST = 1'b1;
    step();
  endtask

  task automatic test_cold_miss();
    do_reset();
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0040;
    #1;
    total++; if (ihit !== 1'b0) $display("FAIL cold_ihit got=%0b exp=0", ihit); else pass++;
    step();
    for (int i = 0; i < 3; i++) begin
      total++; if (iREN !== 1'b1 || iaddr !== 32'h40)
        $display("FAIL cold_wait%0d iREN=%0b iaddr=%h exp 1/00000040", i, iREN, iaddr);
      else pass++;
      step();
    end
    iwait = 1'b0;
    iload = 32'hDEAD_BEEF;
    #1;
    total++; if (iREN !== 1'b1) $display("FAIL cold_last_iREN got=%0b exp=1", iREN); else pass++;
    step();
    iwait = 1'b1;
    #1;
    total++; if (ihit !== 1'b1 || imemload !== 32'hDEAD_BEEF)
      $display("FAIL cold_fill ihit=%0b data=%h exp 1/deadbeef", ihit, imemload);
    else pass++;
    total++; if (iREN !== 1'b0) $display("FAIL cold_iREN_drop got=%0b exp=0", iREN); else pass++;
    total++; if (miss_count !== 16'd1) $display("FAIL cold_count got=%0d exp=1", miss_count);
             else pass++;
  endtask

  task automatic test_warm_hit();
    imemaddr = 32'h0000_0042;
    #1;
    total++; if (ihit !== 1'b1 || imemload !== 32'hDEAD_BEEF)
      $display("FAIL warm_hit ihit=%0b data=%h exp 1/deadbeef", ihit, imemload);
    else pass++;
    step();
    total++; if (iREN !== 1'b0 || miss_count !== 16'd1)
      $display("FAIL warm_state iREN=%0b count=%0d exp 0/1", iREN, miss_count);
    else pass++;
    imemREN = 1'b0;
    #1;
    total++; if (ihit !== 1'b0 || imemload !== 32'h0)
      $display("FAIL idle_no_req ihit=%0b data=%h exp 0/0", ihit, imemload);
    else pass++;
  endtask

  task automatic test_conflict();
    do_reset();
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0000;
    #1;
    do_miss(32'h1111_1111, 0);
    total++; if (ihit !== 1'b1 || imemload !== 32'h1111_1111)
      $display("FAIL conf_fill0 ihit=%0b data=%h exp 1/11111111", ihit, imemload);
    else pass++;
    imemaddr = 32'h0000_0040;
    #1;
    total++; if (ihit !== 1'b0) $display("FAIL conf_miss40 got=%0b exp=0", ihit); else pass++;
    do_miss(32'h2222_2222, 2);
    total++; if (ihit !== 1'b1 || imemload !== 32'h2222_2222)
      $display("FAIL conf_fill40 ihit=%0b data=%h exp 1/22222222", ihit, imemload);
    else pass++;
    imemaddr = 32'h0000_0000;
    #1;
    total++; if (ihit !== 1'b0) $display("FAIL conf_evict got=%0b exp=0", ihit); else pass++;
    do_miss(32'h1111_1111, 0);
    total++; if (ihit !== 1'b1 || imemload !== 32'h1111_1111)
      $display("FAIL conf_refill0 ihit=%0b data=%h exp 1/11111111", ihit, imemload);
    else pass++;
    total++; if (miss_count !== 16'd3) $display("FAIL conf_count got=%0d exp=3", miss_count);
             else pass++;
    imemaddr = 32'h0000_0040;
    #1;
    do_miss(32'h2222_2222, 0);
    total++; if (miss_count !== 16'd4) $display("FAIL conf_count4 got=%0d exp=4", miss_count);
             else pass++;
    total++; if (mc_sat !== 2'd3) $display("FAIL count_saturate got=%0d exp=3", mc_sat);
             else pass++;
  endtask

  task automatic test_redirect();
    do_reset();
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0100;
    #1;
    step();
    imemaddr = 32'h0000_0200;
    #1;
    total++; if (iaddr !== 32'h100) $display("FAIL redir_hold got=%h exp=00000100", iaddr);
             else pass++;
    step();
    total++; if (iREN !== 1'b1 || iaddr !== 32'h100)
      $display("FAIL redir_hold2 iREN=%0b iaddr=%h exp 1/00000100", iREN, iaddr);
    else pass++;
    iwait = 1'b0;
    iload = 32'hAAAA_0100;
    step();
    iwait = 1'b1;
    #1;
    total++; if (ihit !== 1'b0 || iREN !== 1'b0)
      $display("FAIL redir_newmiss ihit=%0b iREN=%0b exp 0/0", ihit, iREN);
    else pass++;
    step();
    total++; if (iaddr !== 32'h200) $display("FAIL redir_2nd got=%h exp=00000200", iaddr);
             else pass++;
    iwait = 1'b0;
    iload = 32'hBBBB_0200;
    step();
    iwait = 1'b1;
    #1;
    total++; if (ihit !== 1'b1 || imemload !== 32'hBBBB_0200)
      $display("FAIL redir_hit200 ihit=%0b data=%h exp 1/bbbb0200", ihit, imemload);
    else pass++;
    // 0x100 and 0x200 share index 0, so the second fill evicts the first.
    imemaddr = 32'h0000_0100;
    #1;
    total++; if (ihit !== 1'b0) $display("FAIL redir_evict got=%0b exp=0", ihit); else pass++;
    total++; if (miss_count !== 16'd2) $display("FAIL redir_count got=%0d exp=2", miss_count);
             else pass++;
    imemREN = 1'b0;
    step();
  endtask

  task automatic test_flush();
    do_reset();
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0010;
    #1;
    do_miss(32'h1010_1010, 1);
    total++; if (ihit !== 1'b1) $display("FAIL flush_prefill got=%0b exp=1", ihit); else pass++;
    flush = 1'b1;
    #1;
    total++; if (ihit !== 1'b0) $display("FAIL flush_force0 got=%0b exp=0", ihit); else pass++;
    step();
    flush = 1'b0;
    #1;
    total++; if (iREN !== 1'b0 || ihit !== 1'b0)
      $display("FAIL flush_after iREN=%0b ihit=%0b exp 0/0", iREN, ihit);
    else pass++;
    do_miss(32'h1010_1010, 0);
    imemaddr = 32'h0000_0020;
    #1;
    total++; if (ihit !== 1'b0) $display("FAIL flush_miss20 got=%0b exp=0", ihit); else pass++;
    step();
    iwait = 1'b0;
    iload = 32'h2020_2020;
    flush = 1'b1;
    step();
    flush = 1'b0;
    iwait = 1'b1;
    #1;
    total++; if (ihit !== 1'b1 || imemload !== 32'h2020_2020)
      $display("FAIL flush_fillwins ihit=%0b data=%h exp 1/20202020", ihit, imemload);
    else pass++;
    imemaddr = 32'h0000_0010;
    #1;
    total++; if (ihit !== 1'b0) $display("FAIL flush_clr10 got=%0b exp=0", ihit); else pass++;
    total++; if (miss_count !== 16'd3) $display("FAIL flush_count got=%0d exp=3", miss_count);
             else pass++;
    imemREN = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0040;
    #1;
    do_miss(32'h4040_4040, 0);
    imemaddr = 32'h0000_0080;
    #1;
    step();
    total++; if (iREN !== 1'b1) $display("FAIL arst_pre got=%0b exp=1", iREN); else pass++;
    nRST = 1'b0;
    #1;
    total++; if (iREN !== 1'b0 || iaddr !== 32'h0)
      $display("FAIL arst_drop iREN=%0b iaddr=%h exp 0/0", iREN, iaddr);
    else pass++;
    #1 nRST = 1'b1;
    imemaddr = 32'h0000_0040;
    #1;
    total++; if (ihit !== 1'b0) $display("FAIL arst_invalid got=%0b exp=0", ihit); else pass++;
    total++; if (miss_count !== 16'd0) $display("FAIL arst_count got=%0d exp=0", miss_count);
             else pass++;
    imemREN = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_warm_hit();
    test_conflict();
    test_redirect();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
